// File: rtl/dispense_timer_pkg.sv
// Shared types and helpers for the dispense countdown timer (package disp_pkg).
// Holds the FSM state encoding, the BCD digit type and the divider/clamp helpers.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // Clock cycles per countdown step; the users of this value reject DIV < 2 at elaboration.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic bcd_t clamp_digit(input bcd_t d);
    if (d > BCD_MAX) begin
      return BCD_MAX;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/dispense_timer_tick_prescaler.sv
// Free-running 0..DIV-1 prescaler; tick flags the terminal count so the parent
// can decide whether to consume it (it stays high while the count is held there).
module tick_prescaler
  import disp_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic RESET,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("tick_prescaler: DIV must be at least 2");
  end

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (count_q == LAST) begin
        count_d = '0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == LAST);

endmodule

// File: rtl/dispense_timer.sv
// Two-digit BCD dispense countdown with start handshake, abort and done pulse.
// Optional pause support is compiled in when DISP_PAUSE_EN is defined.
module dispense_timer
  import disp_pkg::*;
#(
  parameter int         CLK_HZ      = 100000000,
  parameter int         TICK_HZ     = 1,
  parameter logic [7:0] DEFAULT_BCD = 8'h05
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       start_req,
  input  logic [7:0] load_bcd,
  output logic       start_ack,
  input  logic       abort,
  input  logic       pause,
  output logic [3:0] cnt1,
  output logic [3:0] cnt0,
  output logic       busy,
  output logic       done
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

  if (DIV < 2) begin : g_bad_div
    $error("dispense_timer: CLK_HZ/TICK_HZ must be at least 2");
  end

  state_e state_q, state_d;
  bcd_t   cnt1_q, cnt1_d;
  bcd_t   cnt0_q, cnt0_d;
  logic   armed_q, armed_d;
  logic   ack_q, ack_d;
  logic   done_q, done_d;
  logic   busy_q, busy_d;

  logic   tick_s;
  logic   pre_en_s;
  logic   pre_clr_s;
  logic   load_s;
  logic   abort_s;
  logic   dec_s;
  logic   hit_zero_s;
  logic   pause_s;
  bcd_t   ld1_s;
  bcd_t   ld0_s;

`ifdef DISP_PAUSE_EN
  assign pause_s = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_s      = 1'b0;
`endif

  assign load_s     = (state_q == IDLE) && start_req && armed_q;
  assign abort_s    = abort && ((state_q == RUN) || (state_q == PAUSE));
  assign hit_zero_s = (cnt1_q == 4'd0) && (cnt0_q == 4'd1);

  // A terminal count seen while pause rises is held, not consumed, so it fires after resume.
  assign pre_en_s  = (state_q == RUN) && !(pause_s && tick_s);
  assign pre_clr_s = load_s || abort_s;
  assign dec_s     = pre_en_s && tick_s && !abort_s;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .RESET (RESET),
    .en    (pre_en_s),
    .clr   (pre_clr_s),
    .tick  (tick_s)
  );

  always_comb begin
    ld1_s = clamp_digit(load_bcd[7:4]);
    ld0_s = clamp_digit(load_bcd[3:0]);
    if ((ld1_s == 4'd0) && (ld0_s == 4'd0)) begin
      ld1_s = DEFAULT_BCD[7:4];
      ld0_s = DEFAULT_BCD[3:0];
    end else begin
      ld1_s = ld1_s;
      ld0_s = ld0_s;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load_s) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (pause_s) begin
          state_d = PAUSE;
        end else if (dec_s && hit_zero_s) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      PAUSE: begin
`ifdef DISP_PAUSE_EN
        if (abort) begin
          state_d = IDLE;
        end else if (!pause) begin
          state_d = RUN;
        end else begin
          state_d = PAUSE;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    cnt1_d  = cnt1_q;
    cnt0_d  = cnt0_q;
    ack_d   = load_s;
    done_d  = (state_d == DONE);
    busy_d  = (state_d == RUN) || (state_d == PAUSE);
    armed_d = armed_q;
    if (!start_req) begin
      armed_d = 1'b1;
    end else if (load_s) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end
    if (load_s) begin
      cnt1_d = ld1_s;
      cnt0_d = ld0_s;
    end else if (abort_s) begin
      cnt1_d = 4'd0;
      cnt0_d = 4'd0;
    end else if (dec_s) begin
      if (cnt0_q != 4'd0) begin
        cnt0_d = cnt0_q - 4'd1;
      end else begin
        cnt0_d = 4'd9;
        cnt1_d = cnt1_q - 4'd1;
      end
    end else begin
      cnt1_d = cnt1_q;
      cnt0_d = cnt0_q;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      cnt1_q  <= 4'd0;
      cnt0_q  <= 4'd0;
      armed_q <= 1'b1;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt1_q  <= cnt1_d;
      cnt0_q  <= cnt0_d;
      armed_q <= armed_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign cnt1      = cnt1_q;
  assign cnt0      = cnt0_q;
  assign start_ack = ack_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dispense_timer.sv
// Directed bench for dispense_timer at CLK_HZ=10, TICK_HZ=1 (ten cycles per second).
// Pause expectations follow DISP_PAUSE_EN when the bundle is built with it.
module tb_dispense_timer;

  logic       clk;
  logic       RESET;
  logic       start_req;
  logic [7:0] load_bcd;
  logic       start_ack;
  logic       abort;
  logic       pause;
  logic [3:0] cnt1;
  logic [3:0] cnt0;
  logic       busy;
  logic       done;

  int n_checks;
  int n_pass;

  dispense_timer #(
    .CLK_HZ      (10),
    .TICK_HZ     (1),
    .DEFAULT_BCD (8'h05)
  ) dut (
    .clk       (clk),
    .RESET     (RESET),
    .start_req (start_req),
    .load_bcd  (load_bcd),
    .start_ack (start_ack),
    .abort     (abort),
    .pause     (pause),
    .cnt1      (cnt1),
    .cnt0      (cnt0),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic seen_done;
    RESET = 1'b1;
    step();
    step();
    n_checks++; if ({cnt1, cnt0} !== 8'h00) $display("FAIL reset_cnt got %h want 00", {cnt1, cnt0}); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_checks++; if (start_ack !== 1'b0) $display("FAIL reset_ack got %b want 0", start_ack); else n_pass++;
    RESET = 1'b0;
    start_req = 1'b1;
    load_bcd = 8'h03;
    step();
    n_checks++; if (start_ack !== 1'b1) $display("FAIL midreset_ack got %b want 1", start_ack); else n_pass++;
    start_req = 1'b0;
    repeat (14) step();
    n_checks++; if ({cnt1, cnt0} !== 8'h02) $display("FAIL midreset_pre got %h want 02", {cnt1, cnt0}); else n_pass++;
    RESET = 1'b1;
    step();
    n_checks++; if ({cnt1, cnt0, busy, done, start_ack} !== 11'd0) $display("FAIL midreset_clear got %h want 0", {cnt1, cnt0, busy, done, start_ack}); else n_pass++;
    RESET = 1'b0;
    seen_done = 1'b0;
    repeat (30) begin
      step();
      if (done === 1'b1) seen_done = 1'b1;
    end
    n_checks++; if (seen_done !== 1'b0) $display("FAIL midreset_nodone got %b want 0", seen_done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midreset_idle got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_normal();
    start_req = 1'b1;
    load_bcd = 8'h12;
    step();
    n_checks++; if (start_ack !== 1'b1) $display("FAIL normal_ack got %b want 1", start_ack); else n_pass++;
    n_checks++; if ({cnt1, cnt0} !== 8'h12) $display("FAIL normal_load got %h want 12", {cnt1, cnt0}); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL normal_busy got %b want 1", busy); else n_pass++;
    start_req = 1'b0;
    for (int c = 1; c <= 121; c++) begin
      step();
      if (c == 1) begin
        n_checks++; if (start_ack !== 1'b0) $display("FAIL normal_ack_pulse got %b want 0", start_ack); else n_pass++;
      end
      if (c == 9) begin
        n_checks++; if ({cnt1, cnt0} !== 8'h12) $display("FAIL normal_c9 got %h want 12", {cnt1, cnt0}); else n_pass++;
      end
      if (c == 10) begin
        n_checks++; if ({cnt1, cnt0} !== 8'h11) $display("FAIL normal_c10 got %h want 11", {cnt1, cnt0}); else n_pass++;
      end
      if (c == 20) begin
        n_checks++; if ({cnt1, cnt0} !== 8'h10) $display("FAIL normal_c20 got %h want 10", {cnt1, cnt0}); else n_pass++;
      end
      if (c == 30) begin
        n_checks++; if ({cnt1, cnt0} !== 8'h09) $display("FAIL normal_c30 got %h want 09", {cnt1, cnt0}); else n_pass++;
      end
      if (c == 119) begin
        n_checks++; if ({cnt1, cnt0, busy, done} !== 10'b0000_0001_10) $display("FAIL normal_c119 got %b want 0000000110", {cnt1, cnt0, busy, done}); else n_pass++;
      end
      if (c == 120) begin
        n_checks++; if ({cnt1, cnt0, busy, done} !== 10'b0000_0000_01) $display("FAIL normal_done got %b want 0000000001", {cnt1, cnt0, busy, done}); else n_pass++;
      end
      if (c == 121) begin
        n_checks++; if (done !== 1'b0) $display("FAIL normal_done_pulse got %b want 0", done); else n_pass++;
      end
    end
  endtask

  task automatic test_clamp();
    start_req = 1'b1;
    load_bcd = 8'h00;
    step();
    n_checks++; if ({cnt1, cnt0} !== 8'h05) $display("FAIL clamp_zero got %h want 05", {cnt1, cnt0}); else n_pass++;
    start_req = 1'b0;
    for (int c = 1; c <= 51; c++) begin
      step();
      if (c == 49) begin
        n_checks++; if (done !== 1'b0) $display("FAIL clamp_c49 got %b want 0", done); else n_pass++;
      end
      if (c == 50) begin
        n_checks++; if (done !== 1'b1) $display("FAIL clamp_done got %b want 1", done); else n_pass++;
      end
    end
    start_req = 1'b1;
    load_bcd = 8'hA7;
    step();
    n_checks++; if ({cnt1, cnt0} !== 8'h97) $display("FAIL clamp_a7 got %h want 97", {cnt1, cnt0}); else n_pass++;
    start_req = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++; if ({cnt1, cnt0, busy} !== 9'd0) $display("FAIL clamp_abort got %h want 0", {cnt1, cnt0, busy}); else n_pass++;
    step();
  endtask

  task automatic test_rearm();
    int acks;
    start_req = 1'b1;
    load_bcd = 8'h01;
    step();
    n_checks++; if (start_ack !== 1'b1) $display("FAIL rearm_first got %b want 1", start_ack); else n_pass++;
    acks = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (start_ack === 1'b1) acks++;
      if (c == 10) begin
        n_checks++; if (done !== 1'b1) $display("FAIL rearm_done got %b want 1", done); else n_pass++;
      end
    end
    n_checks++; if (acks !== 0) $display("FAIL rearm_held got %0d acks want 0", acks); else n_pass++;
    start_req = 1'b0;
    step();
    start_req = 1'b1;
    step();
    n_checks++; if (start_ack !== 1'b1) $display("FAIL rearm_again got %b want 1", start_ack); else n_pass++;
    start_req = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL rearm_cleanup got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_abort_tick();
    int bad;
    start_req = 1'b1;
    load_bcd = 8'h05;
    step();
    start_req = 1'b0;
    repeat (9) step();
    n_checks++; if ({cnt1, cnt0} !== 8'h05) $display("FAIL abort_pre got %h want 05", {cnt1, cnt0}); else n_pass++;
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++; if ({cnt1, cnt0, busy, done} !== 10'd0) $display("FAIL abort_tick got %b want 0", {cnt1, cnt0, busy, done}); else n_pass++;
    bad = 0;
    repeat (15) begin
      step();
      if ((done === 1'b1) || (start_ack === 1'b1)) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL abort_quiet got %0d pulses want 0", bad); else n_pass++;
  endtask

  task automatic test_start_during_run();
    int acks;
    start_req = 1'b1;
    load_bcd = 8'h02;
    step();
    start_req = 1'b0;
    repeat (3) step();
    start_req = 1'b1;
    load_bcd = 8'h09;
    acks = 0;
    repeat (5) begin
      step();
      if (start_ack === 1'b1) acks++;
    end
    n_checks++; if (acks !== 0) $display("FAIL run_start_ack got %0d want 0", acks); else n_pass++;
    n_checks++; if ({cnt1, cnt0} !== 8'h02) $display("FAIL run_start_cnt got %h want 02", {cnt1, cnt0}); else n_pass++;
    start_req = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
  endtask

  task automatic test_pause();
    start_req = 1'b1;
    load_bcd = 8'h02;
    step();
    start_req = 1'b0;
    for (int c = 1; c <= 46; c++) begin
      if (c == 6) pause = 1'b1;
      if (c == 31) pause = 1'b0;
      step();
`ifdef DISP_PAUSE_EN
      if (c == 30) begin
        n_checks++; if ({cnt1, cnt0, busy} !== 9'b0000_0010_1) $display("FAIL pause_frozen got %b want 000000101", {cnt1, cnt0, busy}); else n_pass++;
      end
      if (c == 35) begin
        n_checks++; if ({cnt1, cnt0} !== 8'h01) $display("FAIL pause_c35 got %h want 01", {cnt1, cnt0}); else n_pass++;
      end
      if (c == 44) begin
        n_checks++; if (done !== 1'b0) $display("FAIL pause_c44 got %b want 0", done); else n_pass++;
      end
      if (c == 45) begin
        n_checks++; if (done !== 1'b1) $display("FAIL pause_done got %b want 1", done); else n_pass++;
      end
`else
      if (c == 10) begin
        n_checks++; if ({cnt1, cnt0} !== 8'h01) $display("FAIL nopause_c10 got %h want 01", {cnt1, cnt0}); else n_pass++;
      end
      if (c == 19) begin
        n_checks++; if (done !== 1'b0) $display("FAIL nopause_c19 got %b want 0", done); else n_pass++;
      end
      if (c == 20) begin
        n_checks++; if (done !== 1'b1) $display("FAIL nopause_done got %b want 1", done); else n_pass++;
      end
`endif
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    RESET = 1'b1;
    start_req = 1'b0;
    load_bcd = 8'h00;
    abort = 1'b0;
    pause = 1'b0;
    test_reset();
    test_normal();
    test_clamp();
    test_rearm();
    test_abort_tick();
    test_start_during_run();
    test_pause();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
